pipo_rr_arbiter: RTL and testbench
==================================

Name: pipo_rr_arbiter

Overview:
- Shares one WIDTH-bit parallel-in/parallel-out holding register between NREQ requesters using round-robin arbitration.
- Each requester presents parallel data and a request. The arbiter picks one winner, loads the winner's data into the shared register, and pulses that requester's grant.
- The arbiter holds the result valid until the downstream consumer acknowledges it.
- Sits between several producer blocks and a single consumer of the register contents.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 4, data width of each requester and of the shared register
SRC_W, $clog2(NREQ), width of source-index output (derived, not overridden)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous active-high reset
req  input  NREQ  per-requester load request, level; held until granted
pin  input  NREQ*WIDTH  requester data, flattened; requester i in slice [i*WIDTH +: WIDTH]
gnt  output  NREQ  one-hot grant, registered, one-cycle pulse on the load edge
pout  output  WIDTH  shared register contents
pout_valid  output  1  pout holds unconsumed data
pout_src  output  SRC_W  index of the requester whose data is in pout
pout_ack  input  1  consumer accepts pout; sampled only while pout_valid=1

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE, pout=0, pout_valid=0, pout_src=0, gnt=0, rr_ptr=0. Outputs take these values immediately on rst assertion, not at the next edge.
- States:
  - IDLE: register empty.
  - HOLD: register full, waiting for pout_ack.
- Winner selection (combinational): the first asserted req at or above rr_ptr, scanning upward modulo NREQ. With rr_ptr=2, NREQ=4, the scan order is 2,3,0,1.
- Load event. Occurs at a rising edge when (state==IDLE and |req) or (state==HOLD and pout_ack and |req). On that edge, simultaneously:
  - pout <= winner slice of pin
  - pout_src <= winner
  - gnt <= onehot(winner)
  - pout_valid <= 1
  - rr_ptr <= (winner+1) mod NREQ
  - state <= HOLD
- Latency: data sampled on the load edge; pout/pout_valid/gnt are visible after that edge. This is 1 cycle from req assertion when idle.
- gnt is high for exactly one cycle per load. A requester must deassert req (or present new data) in the cycle after seeing gnt; a req still high is treated as a new request.
- HOLD, pout_ack=1, no req at the edge: pout_valid <= 0, state <= IDLE. pout retains its last value; pout_src is unchanged.
- HOLD, pout_ack=1 with req pending: back-to-back load; pout_valid stays 1 with no bubble. The grant goes to the next requester in round-robin order.
- HOLD, pout_ack=0: all register contents frozen, gnt=0, requests wait. No requester may overwrite unconsumed data.
- pout_ack while pout_valid=0 is ignored.
- Fairness: a continuously requesting requester waits at most NREQ-1 loads.
- rr_ptr wraps from NREQ-1 to 0.
- Reset mid-HOLD discards held data; the first post-reset grant starts the scan at requester 0.
- Only one register write per edge; no combinational path from req/pin to pout.

Decomposition:
- Package pipo_ctrl_pkg:
  - state enum {IDLE, HOLD}
  - function onehot(idx, n)
  - default NREQ/WIDTH constants
- Sub-module rr_pick (combinational): inputs req, rr_ptr; outputs any, winner index. This keeps the rotate-priority logic isolated and unit-testable.
- The top level holds the FSM, rr_ptr and the data register.

Test Plan:
- Reset: rst=1 with req=4'b1111 and pin all 0xF. Required: pout=0, pout_valid=0, gnt=0, pout_src=0, including when rst asserts asynchronously mid-cycle.
- Single load: idle, req=4'b0100, requester-2 data=4'b1010, pout_ack=0. Required:
  - next edge: pout=4'b1010, pout_src=2, gnt=4'b0100 for 1 cycle, pout_valid=1
  - pout held stable 5 cycles while ack=0
- Round-robin: req=4'b1111 held, pout_ack=1 every cycle, data i = i+1. Required:
  - pout sequence 1,2,3,4,1 with pout_src 0,1,2,3,0
  - pout_valid continuously 1, no bubbles
- Pointer carry-over: requester 1 served, then req=4'b0011 with ack. Required: requester 0 is granted next, since it is the first asserted req when scanning from rr_ptr=2 (order 2,3,0,1).
- Backpressure: HOLD with ack=0, requester 3 asserts req with data 4'b1100. Required: no gnt and pout unchanged. When ack=1 arrives, load 4'b1100 on that same edge with pout_src=3.
- Drain: HOLD, ack=1, req=0. Required: pout_valid->0, pout keeps its value, state IDLE. A later pout_ack while empty has no effect.

Source files
------------

// File: rtl/pipo_ctrl_pkg.sv
// Shared types and helpers for the round-robin PIPO arbiter.
// Holds the controller state encoding, default sizes and a one-hot decoder.
package pipo_ctrl_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 4;
  localparam int MAX_NREQ  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Sets bit idx of an n-wide vector; indices at or beyond n yield zero.
  function automatic logic [MAX_NREQ-1:0] onehot(input int idx, input int n);
    logic [MAX_NREQ-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      if ((i == idx) && (i < n)) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/pipo_rr_arbiter_rr_pick.sv
// Rotating-priority picker: selects the first asserted request at or above
// rr_ptr, scanning upward and wrapping modulo NREQ.
module rr_pick #(
  parameter  int NREQ  = 4,
  localparam int SRC_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [SRC_W-1:0] rr_ptr,
  output logic             any,
  output logic [SRC_W-1:0] winner
);

  int w_idx;

  // Scan from the farthest position back to rr_ptr so the nearest match wins.
  always_comb begin
    any    = |req;
    winner = '0;
    w_idx  = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = (int'(rr_ptr) + k) % NREQ;
      if (req[w_idx]) winner = SRC_W'(w_idx);
    end
  end

endmodule

// File: rtl/pipo_rr_arbiter.sv
// Round-robin arbiter sharing one parallel holding register among NREQ
// producers; the held word stays valid until the consumer acknowledges it.
module pipo_rr_arbiter
  import pipo_ctrl_pkg::*;
#(
  parameter  int NREQ  = DEF_NREQ,
  parameter  int WIDTH = DEF_WIDTH,
  localparam int SRC_W = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] pin,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      pout,
  output logic                  pout_valid,
  output logic [SRC_W-1:0]      pout_src,
  input  logic                  pout_ack
);

  state_t             r_state;
  state_t             w_state_next;
  logic [NREQ-1:0]    r_gnt;
  logic [WIDTH-1:0]   r_pout;
  logic               r_valid;
  logic [SRC_W-1:0]   r_src;
  logic [SRC_W-1:0]   r_rr_ptr;

  logic               w_any;
  logic [SRC_W-1:0]   w_winner;
  logic               w_load;
  logic               w_drain;
  logic [SRC_W-1:0]   w_ptr_next;

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .any    (w_any),
    .winner (w_winner)
  );

  // A load is allowed only when the register is empty or being freed this edge.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_drain      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_load       = 1'b1;
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (pout_ack) begin
          if (w_any) begin
            w_load = 1'b1;
          end else begin
            w_drain      = 1'b1;
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_ptr_next = (w_winner == SRC_W'(NREQ - 1)) ? '0 : w_winner + SRC_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt    <= '0;
      r_pout   <= '0;
      r_valid  <= 1'b0;
      r_src    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_gnt <= '0;
      if (w_load) begin
        r_pout   <= pin[w_winner*WIDTH +: WIDTH];
        r_src    <= w_winner;
        r_gnt    <= NREQ'(onehot(int'(w_winner), NREQ));
        r_valid  <= 1'b1;
        r_rr_ptr <= w_ptr_next;
      end else if (w_drain) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign gnt        = r_gnt;
  assign pout       = r_pout;
  assign pout_valid = r_valid;
  assign pout_src   = r_src;

endmodule

// File: tb/tb_pipo_rr_arbiter.sv
// Directed vector bench for pipo_rr_arbiter (NREQ=4, WIDTH=4).
module tb_pipo_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] pin;
  logic [3:0]  gnt;
  logic [3:0]  pout;
  logic        pout_valid;
  logic [1:0]  pout_src;
  logic        pout_ack;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] pin;
    logic        ack;
    logic [3:0]  gnt;
    logic [3:0]  pout;
    logic        valid;
    logic [1:0]  src;
    string       name;
  } vec_t;

  vec_t vecs[$];

  pipo_rr_arbiter #(
    .NREQ  (4),
    .WIDTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .pin        (pin),
    .gnt        (gnt),
    .pout       (pout),
    .pout_valid (pout_valid),
    .pout_src   (pout_src),
    .pout_ack   (pout_ack)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [15:0] p,
                              input logic a, input logic [3:0] g, input logic [3:0] po,
                              input logic v, input logic [1:0] s, input string nm);
    vec_t t;
    t.rst = r; t.req = rq; t.pin = p; t.ack = a;
    t.gnt = g; t.pout = po; t.valid = v; t.src = s; t.name = nm;
    return t;
  endfunction

  task automatic check(input string nm, input logic [3:0] eg, input logic [3:0] ep,
                       input logic ev, input logic [1:0] es);
    n_vec++;
    $display("[%0t] %s: gnt=%b pout=%h valid=%b src=%0d", $time, nm, gnt, pout, pout_valid, pout_src);
    if (gnt !== eg || pout !== ep || pout_valid !== ev || pout_src !== es) begin
      n_miss++;
      $display("FAIL %s: got gnt=%b pout=%h valid=%b src=%0d, expected gnt=%b pout=%h valid=%b src=%0d",
               nm, gnt, pout, pout_valid, pout_src, eg, ep, ev, es);
    end
  endtask

  initial begin
    // Reset with every requester active and all-ones data.
    vecs.push_back(mk(1, 4'b1111, 16'hFFFF, 0, 4'b0000, 4'h0, 0, 0, "reset"));
    // Single load from requester 2, then five held cycles without ack.
    vecs.push_back(mk(0, 4'b0100, 16'h0A00, 0, 4'b0100, 4'hA, 1, 2, "single_load"));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 4'b0000, 16'h0000, 0, 4'b0000, 4'hA, 1, 2, "hold_no_ack"));
    // Round robin from a fresh pointer, data i = i+1.
    vecs.push_back(mk(1, 4'b0000, 16'h0000, 0, 4'b0000, 4'h0, 0, 0, "rr_reset"));
    vecs.push_back(mk(0, 4'b1111, 16'h4321, 1, 4'b0001, 4'h1, 1, 0, "rr_0"));
    vecs.push_back(mk(0, 4'b1111, 16'h4321, 1, 4'b0010, 4'h2, 1, 1, "rr_1"));
    vecs.push_back(mk(0, 4'b1111, 16'h4321, 1, 4'b0100, 4'h3, 1, 2, "rr_2"));
    vecs.push_back(mk(0, 4'b1111, 16'h4321, 1, 4'b1000, 4'h4, 1, 3, "rr_3"));
    vecs.push_back(mk(0, 4'b1111, 16'h4321, 1, 4'b0001, 4'h1, 1, 0, "rr_wrap"));
    // Pointer carry-over: serve 1, then {1,0} pending scans 2,3,0,1 -> 0.
    vecs.push_back(mk(0, 4'b0010, 16'h4321, 1, 4'b0010, 4'h2, 1, 1, "serve_1"));
    vecs.push_back(mk(0, 4'b0011, 16'h4321, 1, 4'b0001, 4'h1, 1, 0, "carry_over"));
    // Backpressure: requester 3 waits while ack is low.
    vecs.push_back(mk(0, 4'b1000, 16'hC321, 0, 4'b0000, 4'h1, 1, 0, "bp_wait0"));
    vecs.push_back(mk(0, 4'b1000, 16'hC321, 0, 4'b0000, 4'h1, 1, 0, "bp_wait1"));
    vecs.push_back(mk(0, 4'b1000, 16'hC321, 1, 4'b1000, 4'hC, 1, 3, "bp_release"));
    // Drain, then acks while empty are ignored.
    vecs.push_back(mk(0, 4'b0000, 16'h0000, 1, 4'b0000, 4'hC, 0, 3, "drain"));
    vecs.push_back(mk(0, 4'b0000, 16'h0000, 1, 4'b0000, 4'hC, 0, 3, "ack_empty"));
    vecs.push_back(mk(0, 4'b0000, 16'h0000, 0, 4'b0000, 4'hC, 0, 3, "idle_quiet"));
    // From IDLE with rr_ptr=0 after the wrap, requester 0 is next in line.
    vecs.push_back(mk(0, 4'b1001, 16'h9008, 0, 4'b0001, 4'h8, 1, 0, "idle_reload"));

    rst = 1'b1; req = 4'b1111; pin = 16'hFFFF; pout_ack = 1'b0;
    #1;
    check("reset_async_t0", 4'b0000, 4'h0, 1'b0, 2'd0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; req = vecs[i].req; pin = vecs[i].pin; pout_ack = vecs[i].ack;
      @(posedge clk); #1;
      check(vecs[i].name, vecs[i].gnt, vecs[i].pout, vecs[i].valid, vecs[i].src);
    end

    // Asynchronous reset in the middle of a HOLD cycle.
    rst = 1'b0; req = 4'b0100; pin = 16'h0700; pout_ack = 1'b1;
    @(posedge clk); #1;
    check("pre_async_load", 4'b0100, 4'h7, 1'b1, 2'd2);
    req = 4'b0000; pout_ack = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("async_rst_mid", 4'b0000, 4'h0, 1'b0, 2'd0);
    // After reset the scan restarts at 0, so requester 1 beats requester 2.
    req = 4'b0110; pin = 16'h0A50;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_first", 4'b0010, 4'h5, 1'b1, 2'd1);
    req = 4'b0100; pout_ack = 1'b1;
    @(posedge clk); #1;
    check("post_rst_second", 4'b0100, 4'hA, 1'b1, 2'd2);
    req = 4'b0000; pout_ack = 1'b0;
    @(posedge clk); #1;
    check("post_rst_gnt_pulse", 4'b0000, 4'hA, 1'b1, 2'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
